// File: rtl/result_writeback.sv
// result_writeback: requantizes deskewed partial-sum rows from the result-sync
// stage and writes them into the Unified Buffer at base_addr + row.
// Optional build macro: RESULT_WRITEBACK_RELU_EN (clamp negative lanes to 0
// before rounding and saturation).
module result_writeback #(
    parameter int unsigned PARTIAL_SUM_BW = 20,
    parameter int unsigned DATA_BW        = 8,
    parameter int unsigned MATRIX_SIZE    = 8,
    parameter int unsigned ADDRESSSIZE    = 10,
    parameter int unsigned WORDSIZE       = 64,
    parameter int unsigned NUM_ROWS       = 8,
    parameter int unsigned SHIFT          = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [ADDRESSSIZE-1:0]                base_addr,
    input  logic                                  in_valid,
    input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] in_data,
    input  logic                                  ub_grant,
    output logic                                  ub_we,
    output logic [ADDRESSSIZE-1:0]                ub_addr,
    output logic [WORDSIZE-1:0]                   ub_data,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  overflow
);

    localparam int unsigned EXT_W = PARTIAL_SUM_BW + 1;
    localparam int unsigned ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);
    localparam logic signed [EXT_W-1:0] RND     = EXT_W'(1) << (SHIFT - 1);
    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((1 << (DATA_BW - 1)) - 1);
    localparam logic signed [EXT_W-1:0] SAT_MIN = EXT_W'(-(1 << (DATA_BW - 1)));

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic [ADDRESSSIZE-1:0] addr;
        logic [WORDSIZE-1:0]    data;
    } wb_entry_t;

    state_t                 state, state_nxt;
    logic [ADDRESSSIZE-1:0] base_q;
    logic [ROW_W-1:0]       row_cnt;
    wb_entry_t              stage_q;
    logic                   stage_valid;
    wb_entry_t              fifo_mem [2];
    logic                   fifo_rd, fifo_wr;
    logic [1:0]             fifo_cnt;
    logic [WORDSIZE-1:0]    q_word;

    logic start_ok, accept, stage_adv, drop, stage_load;

    // Round-half-up, arithmetic shift, then saturate one lane to DATA_BW.
    function automatic logic [DATA_BW-1:0] requant(input logic signed [PARTIAL_SUM_BW-1:0] x);
        logic signed [EXT_W-1:0] xe;
        logic signed [EXT_W-1:0] sum;
        logic signed [EXT_W-1:0] r;
        xe = {x[PARTIAL_SUM_BW-1], x};
`ifdef RESULT_WRITEBACK_RELU_EN
        if (x[PARTIAL_SUM_BW-1]) begin
            xe = '0;
        end
`endif
        sum = xe + RND;
        r   = sum >>> SHIFT;
        if (r > SAT_MAX) begin
            r = SAT_MAX;
        end else if (r < SAT_MIN) begin
            r = SAT_MIN;
        end
        return DATA_BW'(r);
    endfunction

    // Requantize every lane of the incoming row into one UB word.
    always_comb begin
        q_word = '0;
        for (int i = 0; i < int'(MATRIX_SIZE); i++) begin
            q_word[i*DATA_BW +: DATA_BW] = requant(in_data[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW]);
        end
    end

    // Write issue straight off the FIFO head; data bus is quiet when idle.
    always_comb begin
        ub_we   = (fifo_cnt != 2'd0) && ub_grant;
        ub_addr = '0;
        ub_data = '0;
        if (ub_we) begin
            ub_addr = fifo_mem[fifo_rd].addr;
            ub_data = fifo_mem[fifo_rd].data;
        end
    end

    // Handshake between input, stage register and FIFO.
    always_comb begin
        start_ok   = (state == IDLE) && start;
        accept     = (state == ACTIVE) && in_valid;
        stage_adv  = stage_valid && ((fifo_cnt != 2'd2) || ub_we);
        drop       = accept && stage_valid && !stage_adv;
        stage_load = accept && !drop;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status decode; DRAIN exits once the last queued write issues.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                busy = 1'b1;
                if (in_valid && (row_cnt == LAST_ROW)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (!stage_valid && ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && ub_we))) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Tile bookkeeping: base address, row counter and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q   <= '0;
            row_cnt  <= '0;
            overflow <= 1'b0;
        end else if (start_ok) begin
            base_q   <= base_addr;
            row_cnt  <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            row_cnt <= row_cnt + ROW_W'(1);
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Stage register; a dropped row still consumes its address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q     <= '0;
            stage_valid <= 1'b0;
        end else if (stage_load) begin
            stage_q.addr <= base_q + ADDRESSSIZE'(row_cnt);
            stage_q.data <= q_word;
            stage_valid  <= 1'b1;
        end else if (stage_adv) begin
            stage_valid <= 1'b0;
        end
    end

    // Two-entry write FIFO; push and pop may coincide when full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                fifo_mem[i] <= '0;
            end
            fifo_rd  <= 1'b0;
            fifo_wr  <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (stage_adv) begin
                fifo_mem[fifo_wr] <= stage_q;
                fifo_wr           <= ~fifo_wr;
            end
            if (ub_we) begin
                fifo_rd <= ~fifo_rd;
            end
            case ({stage_adv, ub_we})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_result_writeback.sv
// Directed testbench for result_writeback (default NUM_ROWS=8 instance plus a
// NUM_ROWS=4 instance for address wrap).
module tb_result_writeback;

    localparam int unsigned PSB = 20;
    localparam int unsigned DBW = 8;
    localparam int unsigned MS  = 8;
    localparam int unsigned AW  = 10;
    localparam int unsigned WS  = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              start4 = 1'b0;
    logic [AW-1:0]     base_addr = '0;
    logic              in_valid = 1'b0;
    logic              in_valid4 = 1'b0;
    logic [PSB*MS-1:0] in_data = '0;
    logic              ub_grant = 1'b0;

    logic          ub_we, busy, done, overflow;
    logic [AW-1:0] ub_addr;
    logic [WS-1:0] ub_data;
    logic          ub_we4, busy4, done4, overflow4;
    logic [AW-1:0] ub_addr4;
    logic [WS-1:0] ub_data4;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [WS-1:0] data;
    } wr_t;

    wr_t log_q[$];
    wr_t log4_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;

    result_writeback dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_data(in_data), .ub_grant(ub_grant),
        .ub_we(ub_we), .ub_addr(ub_addr), .ub_data(ub_data),
        .busy(busy), .done(done), .overflow(overflow)
    );

    result_writeback #(.NUM_ROWS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .base_addr(base_addr),
        .in_valid(in_valid4), .in_data(in_data), .ub_grant(ub_grant),
        .ub_we(ub_we4), .ub_addr(ub_addr4), .ub_data(ub_data4),
        .busy(busy4), .done(done4), .overflow(overflow4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Record every UB write seen mid-cycle.
    always @(negedge clk) begin
        wr_t e;
        if (ub_we === 1'b1) begin
            e.cyc = cyc; e.addr = ub_addr; e.data = ub_data;
            log_q.push_back(e);
        end
        if (ub_we4 === 1'b1) begin
            e.cyc = cyc; e.addr = ub_addr4; e.data = ub_data4;
            log4_q.push_back(e);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PSB*MS-1:0] row_all(input int v);
        logic [PSB*MS-1:0] r;
        for (int i = 0; i < int'(MS); i++) r[i*PSB +: PSB] = PSB'(v);
        return r;
    endfunction

    function automatic logic [WS-1:0] word_all(input int v);
        logic [WS-1:0] r;
        for (int i = 0; i < int'(MS); i++) r[i*DBW +: DBW] = DBW'(v);
        return r;
    endfunction

    task automatic start_tile(input logic [AW-1:0] base);
        base_addr = base;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output logic ok);
        int n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        ok = (done === 1'b1);
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({ub_we, ub_addr, ub_data, busy, done, overflow} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: we=%b addr=%h data=%h busy=%b done=%b ovf=%b required all 0",
                     ub_we, ub_addr, ub_data, busy, done, overflow);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || ub_we !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: busy=%b we=%b required 0 0", busy, ub_we);
        end
    endtask

    task automatic test_basic_tile();
        int   c0;
        logic ok;
        log_q.delete();
        ub_grant = 1'b1;
        start_tile(10'h010);
        c0 = cyc;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_data  = row_all(k * 256);
            tick();
        end
        in_valid = 1'b0;
        in_data  = '0;
        wait_done(ok);
        checks++;
        if (!ok || cyc != c0 + 10) begin
            failures++;
            $display("FAIL basic_done: done=%b at cycle %0d required 1 at %0d", done, cyc - c0, 10);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy_in_done: busy=%b required 0", busy);
        end
        checks++;
        if (log_q.size() != 8) begin
            failures++;
            $display("FAIL basic_count: writes=%0d required 8", log_q.size());
        end
        for (int k = 0; k < 8 && k < log_q.size(); k++) begin
            checks++;
            if (log_q[k].addr !== AW'(32'h010 + k) || log_q[k].data !== word_all(k)
                || log_q[k].cyc != c0 + 2 + k) begin
                failures++;
                $display("FAIL basic_row%0d: addr=%h data=%h cyc=%0d required addr=%h data=%h cyc=%0d",
                         k, log_q[k].addr, log_q[k].data, log_q[k].cyc - c0,
                         AW'(32'h010 + k), word_all(k), 2 + k);
            end
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_idle: done=%b busy=%b required 0 0", done, busy);
        end
    endtask

    task automatic test_rounding();
        int            xs[8];
        int            ex[8];
        logic [WS-1:0] exp_w;
        logic          ok;
        xs = '{383, 384, -385, 40000, -40000, 127, 128, -128};
`ifdef RESULT_WRITEBACK_RELU_EN
        ex = '{1, 2, 0, 127, 0, 0, 1, 0};
`else
        ex = '{1, 2, -2, 127, -128, 0, 1, 0};
`endif
        for (int i = 0; i < 8; i++) exp_w[i*DBW +: DBW] = DBW'(ex[i]);
        log_q.delete();
        ub_grant = 1'b1;
        start_tile(10'h100);
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            if (k == 0) begin
                for (int i = 0; i < 8; i++) in_data[i*PSB +: PSB] = PSB'(xs[i]);
            end else begin
                in_data = '0;
            end
            tick();
        end
        in_valid = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok || log_q.size() != 8) begin
            failures++;
            $display("FAIL round_tile: done=%b writes=%0d required 1 8", ok, log_q.size());
        end
        if (log_q.size() >= 2) begin
            checks++;
            if (log_q[0].data !== exp_w || log_q[0].addr !== 10'h100) begin
                failures++;
                $display("FAIL round_lanes: addr=%h data=%h required addr=100 data=%h",
                         log_q[0].addr, log_q[0].data, exp_w);
            end
            checks++;
            if (log_q[1].data !== '0) begin
                failures++;
                $display("FAIL round_zero_row: data=%h required 0", log_q[1].data);
            end
        end
        tick();
    endtask

    task automatic test_grant_stall();
        int   c0;
        logic ok;
        log_q.delete();
        ub_grant = 1'b0;
        start_tile(10'h040);
        c0 = cyc;
        for (int k = 0; k < 8; k++) begin
            if (k == 3) ub_grant = 1'b1;
            in_valid = 1'b1;
            in_data  = row_all(k * 256);
            tick();
        end
        in_valid = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok || overflow !== 1'b0 || log_q.size() != 8) begin
            failures++;
            $display("FAIL stall_summary: done=%b ovf=%b writes=%0d required 1 0 8",
                     ok, overflow, log_q.size());
        end
        for (int k = 0; k < 8 && k < log_q.size(); k++) begin
            checks++;
            if (log_q[k].addr !== AW'(32'h040 + k) || log_q[k].data !== word_all(k)
                || log_q[k].cyc != c0 + 3 + k) begin
                failures++;
                $display("FAIL stall_row%0d: addr=%h data=%h cyc=%0d required addr=%h data=%h cyc=%0d",
                         k, log_q[k].addr, log_q[k].data, log_q[k].cyc - c0,
                         AW'(32'h040 + k), word_all(k), 3 + k);
            end
        end
        tick();
    endtask

    task automatic test_overflow();
        int   rows[7];
        logic ok;
        rows = '{0, 1, 2, 4, 5, 6, 7};
        log_q.delete();
        ub_grant = 1'b0;
        start_tile(10'h080);
        for (int k = 0; k < 8; k++) begin
            if (k == 4) ub_grant = 1'b1;
            in_valid = 1'b1;
            in_data  = row_all(k * 256);
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_flag: overflow=%b required 1", overflow);
        end
        wait_done(ok);
        checks++;
        if (!ok || log_q.size() != 7) begin
            failures++;
            $display("FAIL ovf_tile: done=%b writes=%0d required 1 7", ok, log_q.size());
        end
        for (int j = 0; j < 7 && j < log_q.size(); j++) begin
            checks++;
            if (log_q[j].addr !== AW'(32'h080 + rows[j]) || log_q[j].data !== word_all(rows[j])) begin
                failures++;
                $display("FAIL ovf_write%0d: addr=%h data=%h required addr=%h data=%h",
                         j, log_q[j].addr, log_q[j].data, AW'(32'h080 + rows[j]), word_all(rows[j]));
            end
        end
        tick();
        checks++;
        if (overflow !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ovf_sticky: overflow=%b busy=%b required 1 0", overflow, busy);
        end
        start_tile(10'h0C0);
        checks++;
        if (overflow !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL ovf_clear: overflow=%b busy=%b required 0 1", overflow, busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_a[4];
        int            n = 0;
        exp_a = '{10'd1022, 10'd1023, 10'd0, 10'd1};
        log4_q.delete();
        ub_grant  = 1'b1;
        base_addr = 10'd1022;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid4 = 1'b1;
            in_data   = row_all(k * 256);
            tick();
        end
        in_valid4 = 1'b0;
        while (done4 !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (done4 !== 1'b1 || log4_q.size() != 4) begin
            failures++;
            $display("FAIL wrap_tile: done=%b writes=%0d required 1 4", done4, log4_q.size());
        end
        for (int k = 0; k < 4 && k < log4_q.size(); k++) begin
            checks++;
            if (log4_q[k].addr !== exp_a[k] || log4_q[k].data !== word_all(k)) begin
                failures++;
                $display("FAIL wrap_row%0d: addr=%0d data=%h required addr=%0d data=%h",
                         k, log4_q[k].addr, log4_q[k].data, exp_a[k], word_all(k));
            end
        end
        tick();
    endtask

    task automatic test_reset_and_ignored();
        logic ok;
        log_q.delete();
        ub_grant = 1'b1;
        start_tile(10'h200);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = row_all(k * 256);
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({ub_we, ub_addr, ub_data, busy, done, overflow} !== '0) begin
            failures++;
            $display("FAIL midtile_reset: we=%b addr=%h data=%h busy=%b done=%b ovf=%b required all 0",
                     ub_we, ub_addr, ub_data, busy, done, overflow);
        end
        tick();
        rst = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = row_all(5 * 256);
            tick();
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (log_q.size() != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_ignore: writes=%0d busy=%b required 1 0", log_q.size(), busy);
        end
        log_q.delete();
        start_tile(10'h200);
        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
                start     = 1'b1;
                base_addr = 10'h300;
            end else begin
                start = 1'b0;
            end
            in_valid = 1'b1;
            in_data  = row_all(k * 256);
            tick();
        end
        start    = 1'b0;
        in_valid = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok || log_q.size() != 8) begin
            failures++;
            $display("FAIL busy_start_tile: done=%b writes=%0d required 1 8", ok, log_q.size());
        end
        for (int k = 0; k < 8 && k < log_q.size(); k++) begin
            checks++;
            if (log_q[k].addr !== AW'(32'h200 + k)) begin
                failures++;
                $display("FAIL busy_start_row%0d: addr=%h required %h", k, log_q[k].addr, AW'(32'h200 + k));
            end
        end
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_start_idle: busy=%b required 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic_tile();
        test_rounding();
        test_grant_stall();
        test_overflow();
        test_wrap();
        test_reset_and_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/result_writeback.md
Name: result_writeback

Overview:
- Write-side counterpart of the data-setup path: takes deskewed partial-sum rows from the systolic array's result-sync stage and writes them back into the Unified Buffer.
- Each row of MATRIX_SIZE lanes is requantized to DATA_BW, packed into one UB word and written to base_addr + row.
- Sits between the result-sync controller and the UB write port. A grant signal arbitrates the UB write port against host writes.

Parameters:
- PARTIAL_SUM_BW, 20, signed width of each result lane
- DATA_BW, 8, signed width of each written-back lane
- MATRIX_SIZE, 8, lanes per row
- ADDRESSSIZE, 10, UB address width
- WORDSIZE, 64, UB word width; must equal DATA_BW*MATRIX_SIZE
- NUM_ROWS, 8, rows per tile; must be >= 1
- SHIFT, 8, requantization right-shift amount; must be >= 1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  begin a tile; sampled only in IDLE
- base_addr  in  ADDRESSSIZE  first UB address of tile; latched on accepted start
- in_valid  in  1  in_data carries one result row this cycle
- in_data  in  PARTIAL_SUM_BW*MATRIX_SIZE  lane i at bits [i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW]
- ub_grant  in  1  UB write port is free this cycle
- ub_we  out  1  UB write enable
- ub_addr  out  ADDRESSSIZE  UB write address
- ub_data  out  WORDSIZE  UB write data; lane i at bits [i*DATA_BW +: DATA_BW]
- busy  out  1  high in ACTIVE and DRAIN
- done  out  1  one-cycle pulse at tile completion
- overflow  out  1  sticky: a row was dropped

Behaviour:
- Reset (async, any time, including mid-tile): state=IDLE; all counters and buffers cleared; ub_we=0, ub_addr=0, ub_data=0, busy=0, done=0, overflow=0.
- FSM states: IDLE, ACTIVE, DRAIN, DONE.
  - IDLE -> ACTIVE on start. Latch base_addr; row_cnt=0; clear overflow.
  - ACTIVE -> DRAIN on the edge that accepts row NUM_ROWS-1.
  - DRAIN -> DONE when the stage register and write buffer are both empty.
  - DONE -> IDLE unconditionally. done=1 only in DONE.
- start outside IDLE is ignored. in_valid outside ACTIVE is ignored.
- Requantize, per lane:
  - r = (x + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift, computed at PARTIAL_SUM_BW+1 bits.
  - Saturate r to [-2^(DATA_BW-1), 2^(DATA_BW-1)-1].
- Pipeline:
  - in_valid at cycle t: requantized word plus address (base + row_cnt, wrapping mod 2^ADDRESSSIZE) captured into the stage register at the end of t; row_cnt increments.
  - Stage moves into a 2-entry write FIFO at the end of t+1.
- Write issue:
  - ub_we = FIFO non-empty & ub_grant (combinational). ub_addr/ub_data = FIFO head; they read 0 when ub_we=0.
  - FIFO pops on ub_we. Earliest ub_we is cycle t+2.
  - Rows are written in input order, one write per cycle maximum.
- Overflow:
  - Applies when in_valid arrives while the stage is full and the stage cannot advance (FIFO holds 2 and no pop this cycle).
  - The row is dropped: no write for it, but row_cnt and the address still advance, so the tile always completes. overflow is set and held until the next accepted start or rst.
- Simultaneous push and pop on a full FIFO is legal; the FIFO count is unchanged.
- Address wrap: base_addr=2^ADDRESSSIZE-2 with NUM_ROWS=4 writes addresses 1022, 1023, 0, 1.

Optional Feature:
- Macro RESULT_WRITEBACK_RELU_EN.
- Defined: lanes with x<0 are forced to 0 before rounding and saturation (ReLU), so every output lane is in [0, 2^(DATA_BW-1)-1].
- Undefined: signed requantization exactly as above.

Test Plan:
- Basic tile:
  - Stimulus: ub_grant=1, base_addr=0x010, 8 back-to-back rows. All lanes of row k = k*256.
  - Response: writes to 0x010..0x017 with all lanes = k. First ub_we 2 cycles after the first in_valid. done one cycle after the last write, then busy=0.
- Rounding and saturation:
  - Stimulus: lanes {383, 384, -385, 40000, -40000, 127, 128, -128}.
  - Response: lanes {1, 2, -2, 127, -128, 0, 1, 0}. With RELU_EN: {1, 2, 0, 127, 0, 0, 1, 0}.
- Grant stall:
  - Stimulus: ub_grant=0 for 3 cycles while rows 0-2 arrive back-to-back, then 1.
  - Response: no loss, overflow=0, rows 0-2 written in order on consecutive cycles after grant returns.
- Overflow:
  - Stimulus: ub_grant=0 throughout, 4 back-to-back rows, then grant=1.
  - Response: rows 0-2 written, row 3 dropped (its address never written), overflow=1. Tile still reaches done. overflow clears on the next start.
- Wrap-around:
  - Stimulus: base_addr=1022, NUM_ROWS=4.
  - Response: addresses 1022, 1023, 0, 1.
- Reset and ignored inputs:
  - Stimulus: assert rst mid-tile after 3 rows.
  - Response: all outputs 0 immediately with no further writes. start during busy and in_valid in IDLE produce no writes.
